// File: rtl/rv32i_pkg.sv
// -----------------------------------------------------------------------------
// rv32i_pkg
//   Shared RV32I front-end types and constants.
//   XLEN/ILEN        : datapath and instruction widths
//   RESET_VECTOR     : default PC of the first fetch after reset
//   fetch_state_t    : fetch sequencer states
//   fetch_entry_t    : one buffered instruction together with its PC
//   align_word()     : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package rv32i_pkg;

    localparam int XLEN = 32;
    localparam int ILEN = 32;

    localparam logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        WAIT,
        DROP
    } fetch_state_t;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [ILEN-1:0] insn;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
        return {addr[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_ctrl_if.sv
// -----------------------------------------------------------------------------
// fetch_ctrl_if
//   Bundles the instruction-memory port, the decode handshake, the redirect
//   input and the fault flag of the fetch sequencer.
//   modport master : the fetch sequencer (fetch_ctrl)
//   modport slave  : the surrounding core / memory / decoder
//   imem  : o_imem_req, o_imem_addr, i_imem_gnt, i_imem_rvalid, i_imem_rdata
//   dec   : o_dec_valid, o_dec_opcode, o_dec_pc, i_dec_ready
//   ctrl  : i_redirect, i_redirect_addr, o_fetch_fault
// -----------------------------------------------------------------------------
interface fetch_ctrl_if;
    import rv32i_pkg::*;

    logic            o_imem_req;
    logic [XLEN-1:0] o_imem_addr;
    logic            i_imem_gnt;
    logic            i_imem_rvalid;
    logic [ILEN-1:0] i_imem_rdata;

    logic            o_dec_valid;
    logic [ILEN-1:0] o_dec_opcode;
    logic [XLEN-1:0] o_dec_pc;
    logic            i_dec_ready;

    logic            i_redirect;
    logic [XLEN-1:0] i_redirect_addr;
    logic            o_fetch_fault;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_gnt,
        input  i_imem_rvalid,
        input  i_imem_rdata,
        output o_dec_valid,
        output o_dec_opcode,
        output o_dec_pc,
        input  i_dec_ready,
        input  i_redirect,
        input  i_redirect_addr,
        output o_fetch_fault
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_gnt,
        output i_imem_rvalid,
        output i_imem_rdata,
        input  o_dec_valid,
        input  o_dec_opcode,
        input  o_dec_pc,
        output i_dec_ready,
        output i_redirect,
        output i_redirect_addr,
        input  o_fetch_fault
    );

endinterface

// File: rtl/fetch_ctrl_buf.sv
// -----------------------------------------------------------------------------
// fetch_buf
//   Synchronous FIFO of fetch_entry_t, BUF_DEPTH entries (power of two, >=2).
//   clk, rst_n : clock, asynchronous active-low reset (pointers/count only)
//   push       : write wr_entry at the tail
//   pop        : drop the head entry
//   flush      : empty the FIFO; wins over push and pop
//   rd_entry   : current head (content undefined when empty)
//   full/empty : occupancy flags
//   count      : number of valid entries
//   A push into a full FIFO is accepted only when a pop frees a slot in the
//   same cycle.
// -----------------------------------------------------------------------------
module fetch_buf
    import rv32i_pkg::*;
#(
    parameter int BUF_DEPTH = 2,
    localparam int PTR_W = $clog2(BUF_DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  fetch_entry_t     wr_entry,
    output fetch_entry_t     rd_entry,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [BUF_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty    = (count == '0);
    assign full     = (count == CNT_W'(BUF_DEPTH));
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign rd_entry = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            // Pointers wrap naturally because the depth is a power of two.
            if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr] <= wr_entry;
    end

endmodule

// File: rtl/fetch_ctrl.sv
// -----------------------------------------------------------------------------
// fetch_ctrl
//   RV32I instruction-fetch sequencer. Owns the PC, issues one request at a
//   time on the req/gnt/rvalid memory port, buffers returned words with their
//   PC in fetch_buf and hands them to decode over valid/ready. A redirect
//   flushes the buffer and discards any response still in flight.
//
//   Parameters : RESET_PC  - PC of the first fetch after reset
//                BUF_DEPTH - instruction buffer entries (power of two, >=2)
//   Ports      : i_clk     - clock, rising edge
//                i_rst_n   - asynchronous active-low reset
//                bus       - fetch_ctrl_if.master (imem port, decode
//                            handshake, redirect, fault flag)
//   Build option FETCH_MISALIGN_FAULT_EN:
//                defined   - a redirect with addr[1:0]!=0 sets a sticky
//                            o_fetch_fault and parks the sequencer in IDLE
//                undefined - low address bits are cleared, o_fetch_fault=0
// -----------------------------------------------------------------------------
module fetch_ctrl
    import rv32i_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_VECTOR,
    parameter int              BUF_DEPTH = 2
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    fetch_ctrl_if.master bus
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_t     state_q, state_d;
    logic [XLEN-1:0]  pc_q, pc_d;
    logic [XLEN-1:0]  req_pc_q;
    logic             req;
    logic             accept;
    logic             push;
    logic             pop;
    logic             outstanding;
    logic             slot_free;
    logic             park;
    fetch_state_t     resume_state;
    logic [CNT_W-1:0] buf_count;
    logic [CNT_W-1:0] in_flight;
    logic             buf_full;
    logic             buf_empty;
    fetch_entry_t     wr_entry;
    fetch_entry_t     head;

    // A request may only go out if its response is guaranteed a slot, so the
    // in-flight request is counted as occupying one.
    assign outstanding = (state_q == WAIT) || (state_q == DROP);
    assign in_flight   = buf_count + CNT_W'(outstanding);
    assign slot_free   = !buf_full && (in_flight < CNT_W'(BUF_DEPTH));

`ifdef FETCH_MISALIGN_FAULT_EN
    logic fault_q;
    logic misaligned;

    assign misaligned = |bus.i_redirect_addr[1:0];
    assign park       = fault_q || (bus.i_redirect && misaligned);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            fault_q <= 1'b0;
        end else if (bus.i_redirect && misaligned) begin
            fault_q <= 1'b1;
        end
    end

    assign bus.o_fetch_fault = fault_q;
`else
    assign park              = 1'b0;
    assign bus.o_fetch_fault = 1'b0;
`endif

    // Where the sequencer goes once nothing stale is left in flight.
    assign resume_state = park ? IDLE : REQ;

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        accept  = 1'b0;
        push    = 1'b0;

        if (bus.i_redirect) begin
            pc_d = align_word(bus.i_redirect_addr);
            unique case (state_q)
                // A response still owed by memory must be absorbed in DROP.
                WAIT:    state_d = bus.i_imem_rvalid ? resume_state : DROP;
                DROP:    state_d = bus.i_imem_rvalid ? resume_state : DROP;
                // Memory granted the address it was shown, even though req is
                // withdrawn this cycle; its response must still be swallowed.
                REQ:     state_d = (bus.i_imem_gnt && slot_free) ? DROP : resume_state;
                default: state_d = resume_state;
            endcase
        end else begin
            unique case (state_q)
                IDLE: begin
                    state_d = resume_state;
                end
                REQ: begin
                    req = slot_free;
                    if (req && bus.i_imem_gnt) begin
                        accept  = 1'b1;
                        pc_d    = pc_q + XLEN'(4);
                        state_d = WAIT;
                    end
                end
                WAIT: begin
                    // A gnt seen here is a protocol violation and is ignored.
                    if (bus.i_imem_rvalid) begin
                        push    = 1'b1;
                        state_d = REQ;
                    end
                end
                DROP: begin
                    if (bus.i_imem_rvalid) state_d = resume_state;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    // PC of the request in flight; only meaningful while in WAIT.
    always_ff @(posedge i_clk) begin
        if (accept) req_pc_q <= pc_q;
    end

    assign wr_entry.pc   = req_pc_q;
    assign wr_entry.insn = bus.i_imem_rdata;
    assign pop           = !buf_empty && bus.i_dec_ready;

    fetch_buf #(
        .BUF_DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk      (i_clk),
        .rst_n    (i_rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (bus.i_redirect),
        .wr_entry (wr_entry),
        .rd_entry (head),
        .full     (buf_full),
        .empty    (buf_empty),
        .count    (buf_count)
    );

    assign bus.o_imem_req   = req;
    assign bus.o_imem_addr  = pc_q;
    assign bus.o_dec_valid  = !buf_empty;
    assign bus.o_dec_opcode = buf_empty ? '0 : head.insn;
    assign bus.o_dec_pc     = buf_empty ? '0 : head.pc;

endmodule
